// File: rtl/dcache_sa_ctrl_pkg.sv
// Shared types and width helpers for the set-associative data cache.
// Everything here is elaboration-time only; no logic is generated.
package dcache_pkg;

  typedef enum logic [2:0] {IDLE, WBACK, GAP, ALLOC, FILL} state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int off_w(input int line_bits);
    return clog2(line_bits / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_bits);
    return addr_w - idx_w(sets) - off_w(line_bits);
  endfunction

endpackage

// File: rtl/dcache_sa_ctrl_if.sv
// CPU-side and memory-side bus of the data cache.
// The slave modport is the cache; the master modport is the pipeline plus data memory.
interface dcache_sa_ctrl_if #(
  parameter int ADDR_W    = 32,
  parameter int WORD_W    = 32,
  parameter int LINE_BITS = 256
);
  logic                 cpu_req_i;
  logic                 cpu_we_i;
  logic [ADDR_W-1:0]    cpu_addr_i;
  logic [WORD_W-1:0]    cpu_wdata_i;
  logic [WORD_W-1:0]    cpu_rdata_o;
  logic                 cpu_stall_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_data_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_data_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_way_array.sv
// One cache way: tag, valid, dirty and line storage.
// Asynchronous read by index; synchronous whole-line fill or single-word merge.
module dcache_way_array
  import dcache_pkg::*;
#(
  parameter int  SETS      = 16,
  parameter int  TAG_W     = 23,
  parameter int  LINE_BITS = 256,
  parameter int  WORD_W    = 32,
  localparam int IDX_W     = idx_w(SETS),
  localparam int WSEL_W    = clog2(LINE_BITS / WORD_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_W-1:0]     idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 fill_en,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  input  logic                 word_en,
  input  logic [WSEL_W-1:0]    word_sel,
  input  logic [WORD_W-1:0]    word_data
);

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] line_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = line_q[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; their contents are meaningless until the valid bit is set, and an unreset array can map onto RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      line_q[idx] <= fill_line;
    end else if (word_en) begin
      line_q[idx][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_sa_ctrl.sv
// Write-back, write-allocate, 1- or 2-way set-associative L1 data cache controller.
// Zero-wait hits; misses stall the pipeline through optional write-back, gap, refill and fill.
module dcache_sa_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int WORD_W    = 32,
  parameter int LINE_BITS = 256,
  parameter int SETS      = 16,
  parameter int WAYS      = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_sa_ctrl_if.slave bus
);

  localparam int OFF_W  = off_w(LINE_BITS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BITS);
  localparam int BYTE_W = clog2(WORD_W / 8);
  localparam int WSEL_W = OFF_W - BYTE_W;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    lat_addr_q;
  logic                 victim_q, victim_c;
  logic [LINE_BITS-1:0] fill_q;
  logic [WORD_W-1:0]    rdata_q;
  logic                 en_q, en_d, wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LINE_BITS-1:0] data_q, data_d;

  logic [WAYS-1:0]      way_valid, way_dirty, way_hit, fill_en, word_en;
  logic [TAG_W-1:0]     way_tag  [WAYS];
  logic [LINE_BITS-1:0] way_line [WAYS];

  // Outside IDLE the CPU inputs are ignored and the latched miss address drives the arrays.
  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              unused_byte_bits;

  assign cur_addr         = (state_q == IDLE) ? bus.cpu_addr_i : lat_addr_q;
  assign cur_idx          = cur_addr[OFF_W +: IDX_W];
  assign cur_tag          = cur_addr[ADDR_W-1 -: TAG_W];
  assign word_sel         = cur_addr[BYTE_W +: WSEL_W];
  assign unused_byte_bits = ^cur_addr[BYTE_W-1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way_array #(
      .SETS(SETS), .TAG_W(TAG_W), .LINE_BITS(LINE_BITS), .WORD_W(WORD_W)
    ) u_way (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .idx      (cur_idx),
      .rd_valid (way_valid[w]),
      .rd_dirty (way_dirty[w]),
      .rd_tag   (way_tag[w]),
      .rd_line  (way_line[w]),
      .fill_en  (fill_en[w]),
      .fill_tag (cur_tag),
      .fill_line(fill_q),
      .word_en  (word_en[w]),
      .word_sel (word_sel),
      .word_data(bus.cpu_wdata_i)
    );
    assign way_hit[w] = way_valid[w] & (way_tag[w] == cur_tag);
    assign fill_en[w] = (state_q == FILL) & (victim_q == 1'(w));
    assign word_en[w] = (state_q == IDLE) & bus.cpu_req_i & bus.cpu_we_i & way_hit[w];
  end

  logic              hit, hit_way, load_hit, req_miss;
  logic [WORD_W-1:0] hit_word;

  always_comb begin
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_way = 1'(w);
    end
  end

  assign hit      = |way_hit;
  assign hit_word = way_line[hit_way][word_sel*WORD_W +: WORD_W];
  assign load_hit = (state_q == IDLE) & bus.cpu_req_i & ~bus.cpu_we_i & hit;
  assign req_miss = (state_q == IDLE) & bus.cpu_req_i & ~hit;

  // LRU bit per set names the way to evict next; a hit points it at the other way.
  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        lru_q <= '0;
      end else if ((state_q == IDLE) & bus.cpu_req_i & hit) begin
        lru_q[cur_idx] <= ~hit_way;
      end
    end

    always_comb begin
      if (!way_valid[0])      victim_c = 1'b0;
      else if (!way_valid[1]) victim_c = 1'b1;
      else                    victim_c = lru_q[cur_idx];
    end
  end else begin : g_direct
    assign victim_c = 1'b0;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    en_d    = en_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_miss) begin
          en_d = 1'b1;
          if (way_valid[victim_c] & way_dirty[victim_c]) begin
            state_d = WBACK;
            wr_d    = 1'b1;
            addr_d  = {way_tag[victim_c], cur_idx, {OFF_W{1'b0}}};
            data_d  = way_line[victim_c];
          end else begin
            state_d = ALLOC;
            wr_d    = 1'b0;
            addr_d  = {cur_tag, cur_idx, {OFF_W{1'b0}}};
          end
        end
      end
      WBACK: begin
        if (bus.mem_ack_i) begin
          state_d = GAP;
          en_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      GAP: begin
        state_d = ALLOC;
        en_d    = 1'b1;
        wr_d    = 1'b0;
        addr_d  = {cur_tag, cur_idx, {OFF_W{1'b0}}};
      end
      ALLOC: begin
        if (bus.mem_ack_i) begin
          state_d = FILL;
          en_d    = 1'b0;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      lat_addr_q <= '0;
      victim_q   <= 1'b0;
      fill_q     <= '0;
      rdata_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (req_miss) begin
        lat_addr_q <= bus.cpu_addr_i;
        victim_q   <= victim_c;
      end
      if ((state_q == ALLOC) & bus.mem_ack_i) fill_q <= bus.mem_data_i;
      if (load_hit) rdata_q <= hit_word;
    end
  end

  assign bus.cpu_rdata_o  = load_hit ? hit_word : rdata_q;
  assign bus.cpu_stall_o  = (state_q != IDLE) | (bus.cpu_req_i & ~hit);
  assign bus.mem_enable_o = en_q;
  assign bus.mem_write_o  = wr_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = data_q;

endmodule

// File: tb/tb_dcache_sa_ctrl.sv
// Directed bench for dcache_sa_ctrl: a 2-way/16-set cache and a direct-mapped 4-set cache,
// each against a memory model that acks in the fourth cycle of mem_enable_o.
module tb_dcache_sa_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic force_ack;
  always #5 clk = ~clk;

  dcache_sa_ctrl_if #(.ADDR_W(32), .WORD_W(32), .LINE_BITS(256)) bus_a ();
  dcache_sa_ctrl_if #(.ADDR_W(32), .WORD_W(32), .LINE_BITS(256)) bus_b ();

  dcache_sa_ctrl #(.ADDR_W(32), .WORD_W(32), .LINE_BITS(256), .SETS(16), .WAYS(2)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .bus(bus_a.slave)
  );
  dcache_sa_ctrl #(.ADDR_W(32), .WORD_W(32), .LINE_BITS(256), .SETS(4), .WAYS(1)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .bus(bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Untouched memory: each word holds 0xA000_0000 plus its own byte address.
  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA000_0000 + a + 32'(4 * w);
    return l;
  endfunction

  // Memory model for dut_a, with a small log of written-back lines.
  logic         ack_a = 1'b0;
  int           cnt_a = 0, run_a = 0, last_len_a = 0, wb_cnt_a = 0, rd_cnt_a = 0;
  logic [31:0]  last_wb_addr_a = '0, last_rd_addr_a = '0;
  logic [255:0] last_wb_data_a = '0, rline_a = '0;
  logic [31:0]  wb_addr_log [8];
  logic [255:0] wb_data_log [8];

  function automatic logic [255:0] line_a(input logic [31:0] a);
    logic [255:0] l;
    l = pattern(a);
    for (int i = 0; i < 8; i++) begin
      if (i < wb_cnt_a && wb_addr_log[i] == a) l = wb_data_log[i];
    end
    return l;
  endfunction

  always @(posedge clk) begin
    if (!bus_a.mem_enable_o) begin
      cnt_a <= 0; ack_a <= 1'b0; run_a <= 0;
    end else if (ack_a) begin
      cnt_a <= 0; ack_a <= 1'b0; run_a <= 0;
      last_len_a <= run_a + 1;
      if (bus_a.mem_write_o) begin
        wb_addr_log[wb_cnt_a % 8] <= bus_a.mem_addr_o;
        wb_data_log[wb_cnt_a % 8] <= bus_a.mem_data_o;
        last_wb_addr_a <= bus_a.mem_addr_o;
        last_wb_data_a <= bus_a.mem_data_o;
        wb_cnt_a <= wb_cnt_a + 1;
      end else begin
        last_rd_addr_a <= bus_a.mem_addr_o;
        rd_cnt_a <= rd_cnt_a + 1;
      end
    end else begin
      cnt_a <= cnt_a + 1;
      run_a <= run_a + 1;
      ack_a <= (cnt_a == 2);
      if (cnt_a == 2) rline_a <= line_a(bus_a.mem_addr_o);
    end
  end
  assign bus_a.mem_ack_i  = ack_a | force_ack;
  assign bus_a.mem_data_i = rline_a;

  // Memory model for dut_b: pattern data only, traffic counters.
  logic         ack_b = 1'b0;
  int           cnt_b = 0, wb_cnt_b = 0, rd_cnt_b = 0;
  logic [31:0]  last_rd_addr_b = '0;
  logic [255:0] rline_b = '0;

  always @(posedge clk) begin
    if (!bus_b.mem_enable_o) begin
      cnt_b <= 0; ack_b <= 1'b0;
    end else if (ack_b) begin
      cnt_b <= 0; ack_b <= 1'b0;
      if (bus_b.mem_write_o) wb_cnt_b <= wb_cnt_b + 1;
      else begin
        rd_cnt_b <= rd_cnt_b + 1;
        last_rd_addr_b <= bus_b.mem_addr_o;
      end
    end else begin
      cnt_b <= cnt_b + 1;
      ack_b <= (cnt_b == 2);
      if (cnt_b == 2) rline_b <= pattern(bus_b.mem_addr_o);
    end
  end
  assign bus_b.mem_ack_i  = ack_b;
  assign bus_b.mem_data_i = rline_b;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One CPU access; returns the word seen when stall drops and the number of stalled samples.
  task automatic access(input bit sel_b, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int stalls);
    logic stall;
    @(negedge clk);
    if (sel_b) begin
      bus_b.cpu_req_i = 1'b1; bus_b.cpu_we_i = we; bus_b.cpu_addr_i = addr; bus_b.cpu_wdata_i = wdata;
    end else begin
      bus_a.cpu_req_i = 1'b1; bus_a.cpu_we_i = we; bus_a.cpu_addr_i = addr; bus_a.cpu_wdata_i = wdata;
    end
    #1;
    stalls = 0;
    stall = sel_b ? bus_b.cpu_stall_o : bus_a.cpu_stall_o;
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
      stall = sel_b ? bus_b.cpu_stall_o : bus_a.cpu_stall_o;
    end
    rdata = sel_b ? bus_b.cpu_rdata_o : bus_a.cpu_rdata_o;
    @(negedge clk);
    if (sel_b) begin bus_b.cpu_req_i = 1'b0; bus_b.cpu_we_i = 1'b0; end
    else       begin bus_a.cpu_req_i = 1'b0; bus_a.cpu_we_i = 1'b0; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int st, waited;
    rst_n = 1'b0;
    force_ack = 1'b0;
    bus_a.cpu_req_i = 1'b0; bus_a.cpu_we_i = 1'b0; bus_a.cpu_addr_i = '0; bus_a.cpu_wdata_i = '0;
    bus_b.cpu_req_i = 1'b0; bus_b.cpu_we_i = 1'b0; bus_b.cpu_addr_i = '0; bus_b.cpu_wdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", bus_a.cpu_stall_o, 0);
    check("rst_enable", bus_a.mem_enable_o, 0);
    check("rst_write", bus_a.mem_write_o, 0);
    check("rst_addr", bus_a.mem_addr_o, 0);
    check("rst_data_lo", bus_a.mem_data_o[63:0], 0);
    check("rst_rdata", bus_a.cpu_rdata_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: cold load miss, clean refill of line 0x40
    access(1'b0, 1'b0, 32'h40, 32'h0, rd, st);
    check("t1_stalls", st, 6);
    check("t1_rdata", rd, 32'hA000_0040);
    check("t1_rd_addr", last_rd_addr_a, 32'h40);
    check("t1_enable_len", last_len_a, 4);
    check("t1_wb_cnt", wb_cnt_a, 0);
    check("t1_enable_after", bus_a.mem_enable_o, 0);

    // 2: store hit and reload, no memory traffic
    access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, rd, st);
    check("t2_store_stalls", st, 0);
    access(1'b0, 1'b0, 32'h44, 32'h0, rd, st);
    check("t2_load_stalls", st, 0);
    check("t2_rdata", rd, 32'hDEAD_BEEF);
    check("t2_rd_cnt", rd_cnt_a, 1);
    #1;
    check("t2_rdata_hold", bus_a.cpu_rdata_o, 32'hDEAD_BEEF);

    // 3: fill way 1, then evict dirty LRU way 0 with write-back and gap
    access(1'b0, 1'b0, 32'h240, 32'h0, rd, st);
    check("t3a_stalls", st, 6);
    check("t3a_rdata", rd, 32'hA000_0240);
    check("t3a_wb_cnt", wb_cnt_a, 0);
    access(1'b0, 1'b0, 32'h440, 32'h0, rd, st);
    check("t3b_stalls", st, 11);
    check("t3b_rdata", rd, 32'hA000_0440);
    check("t3b_wb_addr", last_wb_addr_a, 32'h40);
    check("t3b_wb_word1", last_wb_data_a[63:32], 32'hDEAD_BEEF);
    check("t3b_wb_word0", last_wb_data_a[31:0], 32'hA000_0040);
    check("t3b_rd_addr", last_rd_addr_a, 32'h440);
    check("t3b_wb_cnt", wb_cnt_a, 1);

    // 4: dirty both ways, touch 0x440 last, miss 0x640 evicts 0x240
    access(1'b0, 1'b1, 32'h440, 32'h4444_0000, rd, st);
    check("t4_store440_stalls", st, 0);
    access(1'b0, 1'b1, 32'h240, 32'h2222_0000, rd, st);
    check("t4_store240_stalls", st, 0);
    access(1'b0, 1'b0, 32'h440, 32'h0, rd, st);
    check("t4_load440", rd, 32'h4444_0000);
    access(1'b0, 1'b0, 32'h640, 32'h0, rd, st);
    check("t4_miss_stalls", st, 11);
    check("t4_wb_addr", last_wb_addr_a, 32'h240);
    check("t4_wb_word0", last_wb_data_a[31:0], 32'h2222_0000);
    check("t4_rdata", rd, 32'hA000_0640);
    access(1'b0, 1'b0, 32'h440, 32'h0, rd, st);
    check("t4_keep440_stalls", st, 0);
    check("t4_keep440_rdata", rd, 32'h4444_0000);

    // 5: reset while a refill is outstanding, then a stray ack
    @(negedge clk);
    bus_a.cpu_req_i = 1'b1; bus_a.cpu_we_i = 1'b0; bus_a.cpu_addr_i = 32'h60;
    waited = 0;
    while (!bus_a.mem_enable_o && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("t5_alloc_enable", bus_a.mem_enable_o, 1);
    check("t5_alloc_addr", bus_a.mem_addr_o, 32'h60);
    @(negedge clk);
    rst_n = 1'b0;
    bus_a.cpu_req_i = 1'b0;
    #1;
    check("t5_enable_drop", bus_a.mem_enable_o, 0);
    check("t5_stall_drop", bus_a.cpu_stall_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    #1;
    check("t5_late_ack_enable", bus_a.mem_enable_o, 0);
    check("t5_late_ack_stall", bus_a.cpu_stall_o, 0);
    check("t5_rdata_cleared", bus_a.cpu_rdata_o, 0);
    check("t5_rd_cnt", rd_cnt_a, 4);
    access(1'b0, 1'b0, 32'h40, 32'h0, rd, st);
    check("t5_reload_stalls", st, 6);
    check("t5_reload_rdata", rd, 32'hA000_0040);
    access(1'b0, 1'b0, 32'h44, 32'h0, rd, st);
    check("t5_written_back", rd, 32'hDEAD_BEEF);

    // 6: direct-mapped, 4 sets: 0x00 and 0x80 share index 0
    access(1'b1, 1'b0, 32'h00, 32'h0, rd, st);
    check("t6a_stalls", st, 6);
    check("t6a_rdata", rd, 32'hA000_0000);
    access(1'b1, 1'b0, 32'h80, 32'h0, rd, st);
    check("t6b_stalls", st, 6);
    check("t6b_rdata", rd, 32'hA000_0080);
    check("t6b_rd_addr", last_rd_addr_b, 32'h80);
    access(1'b1, 1'b0, 32'h00, 32'h0, rd, st);
    check("t6c_stalls", st, 6);
    check("t6c_rdata", rd, 32'hA000_0000);
    check("t6_wb_cnt", wb_cnt_b, 0);
    check("t6_rd_cnt", rd_cnt_b, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
